// File: rtl/i2c_target.sv
// I2C target with a 4 x 8-bit register bank: pointer write, burst write/read, pointer wrap 3->0.
// Input latency SYNC_STAGES+1 clk (+2 with I2C_TARGET_GLITCH_FILTER_EN); no backpressure, SCL is never stretched.
module i2c_target #(
    parameter logic [6:0] DEV_ADDR    = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    output logic [31:0] regs_out,
    output logic        wr_strobe,
    output logic [1:0]  wr_index,
    output logic        busy
);

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        WAIT_STOP
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_s, sda_s;
    logic                   scl_f, sda_f;

    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
        end
    end

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    // Registered 2-of-3 vote over the current and two previous samples.
    logic [1:0] scl_hist_q, scl_hist_d;
    logic [1:0] sda_hist_q, sda_hist_d;
    logic       scl_filt_q, scl_filt_d;
    logic       sda_filt_q, sda_filt_d;

    always_comb begin
        scl_hist_d = {scl_hist_q[0], scl_s};
        sda_hist_d = {sda_hist_q[0], sda_s};
        scl_filt_d = (scl_s & scl_hist_q[0]) | (scl_s & scl_hist_q[1]) | (scl_hist_q[0] & scl_hist_q[1]);
        sda_filt_d = (sda_s & sda_hist_q[0]) | (sda_s & sda_hist_q[1]) | (sda_hist_q[0] & sda_hist_q[1]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_hist_q <= '1;
            sda_hist_q <= '1;
            scl_filt_q <= 1'b1;
            sda_filt_q <= 1'b1;
        end else begin
            scl_hist_q <= scl_hist_d;
            sda_hist_q <= sda_hist_d;
            scl_filt_q <= scl_filt_d;
            sda_filt_q <= sda_filt_d;
        end
    end

    assign scl_f = scl_filt_q;
    assign sda_f = sda_filt_q;
`else
    assign scl_f = scl_s;
    assign sda_f = sda_s;
`endif

    state_t      state_q, state_d;
    logic        scl_prev_q, scl_prev_d;
    logic        sda_prev_q, sda_prev_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [31:0] regs_q, regs_d;
    logic        rw_q, rw_d;
    logic        mack_q, mack_d;
    logic        sda_oe_q, sda_oe_d;
    logic        busy_q, busy_d;
    logic        wr_strobe_q, wr_strobe_d;
    logic [1:0]  wr_index_q, wr_index_d;

    logic        scl_rise, scl_fall, start_det, stop_det;
    logic [1:0]  ptr_inc;
    logic [7:0]  cur_byte, nxt_byte;

    assign scl_rise  = scl_f & ~scl_prev_q;
    assign scl_fall  = ~scl_f & scl_prev_q;
    assign start_det = scl_f & scl_prev_q & sda_prev_q & ~sda_f;
    assign stop_det  = scl_f & scl_prev_q & ~sda_prev_q & sda_f;
    assign ptr_inc   = ptr_q + 2'd1;
    assign cur_byte  = regs_q[{ptr_q, 3'b000} +: 8];
    assign nxt_byte  = regs_q[{ptr_inc, 3'b000} +: 8];

    always_comb begin
        state_d     = state_q;
        scl_prev_d  = scl_f;
        sda_prev_d  = sda_f;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        ptr_d       = ptr_q;
        regs_d      = regs_q;
        rw_d        = rw_q;
        mack_d      = mack_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        wr_strobe_d = 1'b0;
        wr_index_d  = wr_index_q;

        if (start_det) begin
            // Repeated START deliberately leaves ptr alone.
            state_d  = ADDR;
            cnt_d    = 4'd0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (stop_det) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (scl_rise) begin
            unique case (state_q)
                ADDR, PTR, WR_DATA: begin
                    shift_d = {shift_q[6:0], sda_f};
                    if (cnt_q < 4'd8) cnt_d = cnt_q + 4'd1;
                end
                RD_DATA: begin
                    if (cnt_q < 4'd8) cnt_d = cnt_q + 4'd1;
                end
                RD_ACK:  mack_d = ~sda_f;
                default: ;
            endcase
        end else if (scl_fall) begin
            // All SDA drive changes happen here, while SCL is low.
            unique case (state_q)
                ADDR: begin
                    if (cnt_q == 4'd8) begin
                        if (shift_q[7:1] == DEV_ADDR) begin
                            state_d  = ADDR_ACK;
                            busy_d   = 1'b1;
                            sda_oe_d = 1'b1;
                            rw_d     = shift_q[0];
                        end else begin
                            state_d  = WAIT_STOP;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                ADDR_ACK: begin
                    cnt_d = 4'd0;
                    if (rw_q) begin
                        state_d  = RD_DATA;
                        shift_d  = cur_byte;
                        sda_oe_d = ~cur_byte[7];
                    end else begin
                        state_d  = PTR;
                        sda_oe_d = 1'b0;
                    end
                end
                PTR: begin
                    if (cnt_q == 4'd8) begin
                        state_d  = PTR_ACK;
                        ptr_d    = shift_q[1:0];
                        sda_oe_d = 1'b1;
                    end
                end
                WR_DATA: begin
                    if (cnt_q == 4'd8) begin
                        state_d                       = WR_ACK;
                        regs_d[{ptr_q, 3'b000} +: 8] = shift_q;
                        wr_strobe_d                   = 1'b1;
                        wr_index_d                    = ptr_q;
                        ptr_d                         = ptr_inc;
                        sda_oe_d                      = 1'b1;
                    end
                end
                PTR_ACK, WR_ACK: begin
                    state_d  = WR_DATA;
                    cnt_d    = 4'd0;
                    sda_oe_d = 1'b0;
                end
                RD_DATA: begin
                    if (cnt_q == 4'd8) begin
                        state_d  = RD_ACK;
                        sda_oe_d = 1'b0;
                    end else begin
                        shift_d  = {shift_q[6:0], 1'b0};
                        sda_oe_d = ~shift_q[6];
                    end
                end
                RD_ACK: begin
                    if (mack_q) begin
                        state_d  = RD_DATA;
                        ptr_d    = ptr_inc;
                        shift_d  = nxt_byte;
                        sda_oe_d = ~nxt_byte[7];
                        cnt_d    = 4'd0;
                    end else begin
                        state_d  = WAIT_STOP;
                        sda_oe_d = 1'b0;
                    end
                end
                default: sda_oe_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            scl_prev_q  <= 1'b1;
            sda_prev_q  <= 1'b1;
            cnt_q       <= 4'd0;
            shift_q     <= 8'h00;
            ptr_q       <= 2'd0;
            regs_q      <= 32'h0;
            rw_q        <= 1'b0;
            mack_q      <= 1'b0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_index_q  <= 2'd0;
        end else begin
            state_q     <= state_d;
            scl_prev_q  <= scl_prev_d;
            sda_prev_q  <= sda_prev_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            regs_q      <= regs_d;
            rw_q        <= rw_d;
            mack_q      <= mack_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            wr_strobe_q <= wr_strobe_d;
            wr_index_q  <= wr_index_d;
        end
    end

    assign sda_oe    = sda_oe_q;
    assign regs_out  = regs_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_index  = wr_index_q;
    assign busy      = busy_q;

endmodule

// File: doc/i2c_target.md
I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 The block SHALL have parameter DEV_ADDR, default 7'h42, meaning the 7-bit I2C address the block responds to.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, meaning the number of synchronizer flops on scl_in and sda_in (minimum 2).
REQ-003 The block SHALL have these ports, one per line: name, direction, width, meaning.
  clk  input  1  system clock; all logic runs on its rising edge.
  reset  input  1  asynchronous, active-high reset.
  scl_in  input  1  raw SCL from the pad.
  sda_in  input  1  raw SDA from the pad.
  sda_oe  output  1  open-drain enable; 1 pulls SDA low, 0 releases it.
  regs_out  output  32  register bank; reg[i] occupies bits [8i+7:8i].
  wr_strobe  output  1  one-clk pulse for each data byte written.
  wr_index  output  2  index of the register written; valid while wr_strobe=1.
  busy  output  1  high from an address match until STOP or the next START.

Function
REQ-004 scl_in and sda_in SHALL pass through SYNC_STAGES flops; SCL edges SHALL be detected on the synchronized signals.
REQ-005 START (SDA falling while SCL high) SHALL enter state ADDR from any state, clear the bit counter, and release sda_oe.
REQ-006 STOP (SDA rising while SCL high) SHALL enter IDLE from any state and clear busy.
REQ-007 Data bits SHALL be sampled on the SCL rising edge, MSB first; sda_oe SHALL change only on SCL falling edges.
REQ-008 The states SHALL be IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK and WAIT_STOP.
REQ-009 ADDR: after 8 bits, if bits[7:1]==DEV_ADDR the block SHALL set busy, drive sda_oe=1 for the 9th SCL cycle, and go to ADDR_ACK.
REQ-010 ADDR on mismatch: the block SHALL release SDA and go to WAIT_STOP.
REQ-011 ADDR_ACK: on R/W=0 the next state SHALL be PTR; on R/W=1 it SHALL be RD_DATA with reg[ptr] loaded into the shift register.
REQ-012 PTR: ptr SHALL be set to byte[1:0], upper bits ignored; the block SHALL ACK and then go to WR_DATA.
REQ-013 WR_DATA: after 8 bits the block SHALL write reg[ptr], pulse wr_strobe with wr_index=ptr, ACK, set ptr=ptr+1 mod 4, and repeat for each further byte.
REQ-014 RD_DATA: the block SHALL drive sda_oe = ~shift_bit from each SCL falling edge, then release SDA for bit 9.
REQ-015 RD_ACK on ACK (SDA=0): ptr SHALL become ptr+1 mod 4, reg[ptr] SHALL be loaded, and the state SHALL return to RD_DATA; on NACK the state SHALL be WAIT_STOP.
REQ-016 Pointer wrap: ptr SHALL wrap 3 -> 0 for both reads and writes.
REQ-017 Repeated START SHALL keep ptr, enabling a write-pointer-then-read sequence.
REQ-018 The block SHALL require SCL high and low phases of at least SYNC_STAGES+3 clk cycles each.
REQ-019 sda_oe SHALL never be 1 in IDLE or WAIT_STOP.

Reset
REQ-020 Reset SHALL give: state=IDLE, sda_oe=0, regs_out=32'h0, wr_strobe=0, wr_index=0, busy=0, ptr=0, synchronizers=1.
REQ-021 Reset asserted mid-transfer SHALL release SDA within the same cycle (asynchronous) and discard any partial byte.

Configuration
REQ-022 With I2C_TARGET_GLITCH_FILTER_EN defined, synchronized SCL and SDA SHALL pass a 3-sample majority filter before edge detection; pulses of 1 clk SHALL be ignored and latency SHALL increase by 2 clk.
REQ-023 Without I2C_TARGET_GLITCH_FILTER_EN, the synchronized signals SHALL feed edge detection directly and the filter logic SHALL be absent.

Verification
REQ-024 Write scenario: START, 0x84, 0x01, 0xA5, STOP -> three ACKs, reg1=0xA5, one wr_strobe with wr_index=1.
REQ-025 Address mismatch: START, 0x86, 0x00, STOP -> no ACK on any bit, regs_out unchanged, busy stays 0.
REQ-026 Wrap on write: START, 0x84, 0x03, 0x11, 0x22, STOP -> reg3=0x11, reg0=0x22, wr_index sequence 3 then 0.
REQ-027 Read after pointer set: START, 0x84, 0x03, Sr, 0x85; master ACKs byte 1 and NACKs byte 2 -> bytes 0x11 then 0x22 on SDA, then SDA released and state WAIT_STOP.
REQ-028 Reset mid-byte: reset asserted during bit 4 of a write-data byte -> sda_oe=0 immediately, regs_out=0, next START/0x84 ACKed normally.
REQ-029 Glitch (macro defined): a 1-clk SCL low pulse during the address byte -> bit count unchanged, and the transfer completes as in REQ-024.
